// File: rtl/lcd_reader.sv
// lcd_reader: 4-bit HD44780-style panel read sequencer (two nibbles per byte); define LCD_BUSY_POLL_EN to enable busy-flag polling
module lcd_reader #(
  parameter int T_SETUP  = 2,
  parameter int T_EH     = 12,
  parameter int T_HOLD   = 2,
  parameter int T_GAP    = 50,
  parameter int POLL_MAX = 255
) (
  input  logic       CLK_50M,
  input  logic       rst,
  input  logic       req,
  input  logic       rs_sel,
  input  logic       poll,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       timeout,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  input  logic [3:0] LCD_DB_I,
  output logic       strataflash_ce
);
  typedef enum logic [3:0] {IDLE, SETUP_H, EH_H, HOLD_H, GAP, SETUP_L, EH_L, HOLD_L, DONE} state_t;
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        rs_q;
  logic [7:0]  rd_data_q;
  logic        last, again, rep;
  assign last = cnt_q == 16'd0;
  assign strataflash_ce = 1'b1;
  assign busy    = state_q != IDLE && state_q != DONE;
  assign done    = state_q == DONE;
  assign LCD_E   = state_q == EH_H || state_q == EH_L;
  assign LCD_RW  = busy;
  assign LCD_RS  = busy && rs_q;
  assign rd_data = rd_data_q;
`ifdef LCD_BUSY_POLL_EN
  localparam int PW = $clog2(POLL_MAX + 1);
  logic          poll_q, rep_q, timeout_q, bf;
  logic [PW-1:0] pcnt_q;
  assign bf      = poll_q && !rs_q && rd_data_q[7];
  assign again   = bf && (int'(pcnt_q) + 1 < POLL_MAX);
  assign rep     = rep_q;
  assign timeout = timeout_q;
  // poll bookkeeping: read count, repeat-from-high-nibble flag and timeout flag
  always_ff @(posedge CLK_50M or posedge rst) begin
    if (rst) begin
      poll_q    <= 1'b0;
      rep_q     <= 1'b0;
      timeout_q <= 1'b0;
      pcnt_q    <= '0;
    end else if (state_q == IDLE && req) begin
      poll_q    <= poll;
      rep_q     <= 1'b0;
      timeout_q <= 1'b0;
      pcnt_q    <= '0;
    end else if (state_q == HOLD_L && last) begin
      rep_q     <= again;
      timeout_q <= bf && !again;
      pcnt_q    <= again ? pcnt_q + 1'b1 : pcnt_q;
    end else if (state_q == GAP && last) begin
      rep_q     <= 1'b0;
    end
  end
`else
  logic unused_poll;
  assign unused_poll = poll & (POLL_MAX > 0);
  assign again   = 1'b0;
  assign rep     = 1'b0;
  assign timeout = 1'b0;
`endif
  // next state and per-state down-counter reload on every state change
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = req ? SETUP_H : IDLE;
      SETUP_H: state_d = last ? EH_H : SETUP_H;
      EH_H:    state_d = last ? HOLD_H : EH_H;
      HOLD_H:  state_d = last ? GAP : HOLD_H;
      GAP:     state_d = !last ? GAP : rep ? SETUP_H : SETUP_L;
      SETUP_L: state_d = last ? EH_L : SETUP_L;
      EH_L:    state_d = last ? HOLD_L : EH_L;
      HOLD_L:  state_d = !last ? HOLD_L : again ? GAP : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cnt_d = state_d == state_q ? (last ? cnt_q : cnt_q - 16'd1) :
            (state_d == SETUP_H || state_d == SETUP_L) ? 16'(T_SETUP - 1) :
            (state_d == EH_H || state_d == EH_L)       ? 16'(T_EH - 1) :
            (state_d == HOLD_H || state_d == HOLD_L)   ? 16'(T_HOLD - 1) :
            state_d == GAP                             ? 16'(T_GAP - 1) : 16'd0;
  end
  // state, counter, latched select and nibble capture on the last E-high clock
  always_ff @(posedge CLK_50M or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 16'd0;
      rs_q      <= 1'b0;
      rd_data_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && req) rs_q <= rs_sel;
      if (state_q == EH_H && last) rd_data_q[7:4] <= LCD_DB_I;
      if (state_q == EH_L && last) rd_data_q[3:0] <= LCD_DB_I;
    end
  end
endmodule

// File: tb/tb_lcd_reader.sv
// tb_lcd_reader: table-driven and randomized checks of lcd_reader against a transaction-level model
module tb_lcd_reader;
  localparam int TS = 2, TE = 12, TH = 2, TG = 50, PM = 4;
  localparam int PER = 2 * (TS + TE + TH) + TG;
  typedef struct {
    logic            rs;
    logic            pl;
    logic [3:0][7:0] b;
    int              repulse;
    int              reads;
    logic [7:0]      data;
    logic            to;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, req = 1'b0, rs_sel = 1'b0, poll = 1'b0;
  logic busy, done, timeout, lcd_e, lcd_rs, lcd_rw, sf_ce;
  logic [7:0] rd_data;
  logic [3:0] db = 4'h0;
  int tests = 0, fails = 0;
  int cyc = 0, e_run = 0, gap_run = 0, pulses = 0, done_cnt = 0, bad_ctl = 0;
  bit prev_e = 0, had_fall = 0;
  logic exp_rs = 1'b0;
  int widths[$], gaps[$], dtimes[$];
  logic [3:0] nibq[$];
  vec_t tbl[$];
  vec_t v;

  lcd_reader #(.T_SETUP(TS), .T_EH(TE), .T_HOLD(TH), .T_GAP(TG), .POLL_MAX(PM)) dut (
    .CLK_50M(clk), .rst(rst), .req(req), .rs_sel(rs_sel), .poll(poll),
    .busy(busy), .done(done), .rd_data(rd_data), .timeout(timeout),
    .LCD_E(lcd_e), .LCD_RS(lcd_rs), .LCD_RW(lcd_rw), .LCD_DB_I(db),
    .strataflash_ce(sf_ce));

  initial forever #5 clk = ~clk;

  // panel model and bus observer, sampled away from the rising edge
  always @(negedge clk) begin
    cyc++;
    if (lcd_e) begin
      if (!prev_e) begin
        pulses++;
        if (had_fall) gaps.push_back(gap_run);
      end
      e_run++;
    end else begin
      if (prev_e) begin
        widths.push_back(e_run);
        e_run = 0;
        gap_run = 0;
        had_fall = 1;
        if (nibq.size() > 0) void'(nibq.pop_front());
      end
      gap_run++;
    end
    if (done) begin
      done_cnt++;
      dtimes.push_back(cyc);
    end
    if (busy && !(lcd_rw && lcd_rs == exp_rs)) bad_ctl++;
    if (!busy && (lcd_rw || lcd_rs || lcd_e)) bad_ctl++;
    prev_e = lcd_e;
    db = nibq.size() > 0 ? nibq[0] : 4'h0;
  end

  task automatic chk(input string n, input int a, input int e);
    tests++;
    if (a != e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  task automatic clear();
    e_run = 0; gap_run = 0; pulses = 0; done_cnt = 0; bad_ctl = 0; had_fall = 0;
    widths.delete(); gaps.delete(); dtimes.delete(); nibq.delete();
  endtask

  function automatic vec_t model(input vec_t x);
    bit pe;
    int r;
`ifdef LCD_BUSY_POLL_EN
    pe = x.pl && !x.rs;
`else
    pe = 0;
`endif
    r = 1;
    while (pe && x.b[r-1][7] && r < PM) r++;
    x.reads = r;
    x.data = x.b[r-1];
    x.to = pe && x.data[7];
    return x;
  endfunction

  function automatic vec_t mk(input logic rs, input logic pl, input logic [3:0][7:0] b, input int rp,
                              input int reads, input logic [7:0] data, input logic to);
    vec_t x;
    x.rs = rs; x.pl = pl; x.b = b; x.repulse = rp; x.reads = reads; x.data = data; x.to = to;
    return x;
  endfunction

  task automatic txn(input string nm, input vec_t x);
    int k, lat, wbad, gbad;
    clear();
    lat = x.reads * PER + (x.reads - 1) * TG;
    exp_rs = x.rs;
    for (int i = 0; i < x.reads; i++) begin
      nibq.push_back(x.b[i][7:4]);
      nibq.push_back(x.b[i][3:0]);
    end
    @(negedge clk);
    req = 1'b1; rs_sel = x.rs; poll = x.pl;
    @(posedge clk); #1 req = 1'b0;
    k = 0;
    while (k < lat + 20 && !done) begin
      @(posedge clk); #1;
      k++;
      req = (k == x.repulse);
    end
    req = 1'b0;
    chk({nm, "_latency"}, k, lat);
    chk({nm, "_rd_data"}, int'(rd_data), int'(x.data));
    chk({nm, "_timeout"}, int'(timeout), int'(x.to));
    chk({nm, "_busy_at_done"}, int'(busy), 0);
    repeat (30) @(posedge clk);
    #1;
    wbad = 0; gbad = 0;
    foreach (widths[i]) if (widths[i] != TE) wbad++;
    foreach (gaps[i]) if (gaps[i] != TH + TG + TS) gbad++;
    chk({nm, "_done_count"}, done_cnt, 1);
    chk({nm, "_e_pulses"}, pulses, 2 * x.reads);
    chk({nm, "_e_width_bad"}, wbad, 0);
    chk({nm, "_e_gap_bad"}, gbad, 0);
    chk({nm, "_ctl_bad"}, bad_ctl, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_rd_data", int'(rd_data), 0);
    chk("reset_timeout", int'(timeout), 0);
    chk("reset_lcd", int'({lcd_e, lcd_rs, lcd_rw}), 0);
    chk("reset_sf_ce", int'(sf_ce), 1);
    @(negedge clk) rst = 1'b0;

    tbl.push_back(mk(1'b1, 1'b0, {8'h0, 8'h0, 8'h0, 8'h41}, 0, 1, 8'h41, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, {8'h0, 8'h0, 8'h0, 8'h85}, 0, 1, 8'h85, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, {8'h0, 8'h0, 8'h0, 8'h41}, 20, 1, 8'h41, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, {8'h0, 8'h0, 8'h0, 8'hFF}, 0, 1, 8'hFF, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, {8'h0, 8'h0, 8'h0, 8'h00}, 0, 1, 8'h00, 1'b0));
`ifdef LCD_BUSY_POLL_EN
    tbl.push_back(mk(1'b0, 1'b1, {8'h05, 8'h8C, 8'h8B, 8'h8A}, 0, 4, 8'h05, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, {8'h94, 8'h93, 8'h92, 8'h91}, 0, 4, 8'h94, 1'b1));
`else
    tbl.push_back(mk(1'b0, 1'b1, {8'h05, 8'h8C, 8'h8B, 8'h8A}, 0, 1, 8'h8A, 1'b0));
`endif
    foreach (tbl[i]) txn($sformatf("vec%0d", i), tbl[i]);

    for (int i = 0; i < 8; i++) begin
      v.rs = 1'($urandom_range(0, 1));
      v.pl = 1'($urandom_range(0, 1));
      v.b = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
      v.repulse = 0;
      txn($sformatf("rnd%0d", i), model(v));
    end

    clear();
    exp_rs = 1'b1;
    nibq.push_back(4'h4); nibq.push_back(4'h1);
    @(negedge clk);
    req = 1'b1; rs_sel = 1'b1; poll = 1'b0;
    @(posedge clk); #1 req = 1'b0;
    repeat (2 * TS + TE + 2 * TH + TG + 6) @(posedge clk);
    #1 chk("rst_mid_e_high", int'(lcd_e), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_e_drop", int'(lcd_e), 0);
    chk("rst_mid_rd_data", int'(rd_data), 0);
    chk("rst_mid_busy", int'(busy), 0);
    @(negedge clk) rst = 1'b0;
    repeat (100) @(posedge clk);
    #1 chk("rst_mid_no_done", done_cnt, 0);

    clear();
    exp_rs = 1'b1;
    repeat (3) begin
      nibq.push_back(4'h3); nibq.push_back(4'hC);
    end
    @(negedge clk);
    req = 1'b1; rs_sel = 1'b1; poll = 1'b0;
    repeat (200) @(posedge clk);
    #1 req = 1'b0;
    repeat (150) @(posedge clk);
    #1;
    chk("hold_done_count", done_cnt, 3);
    chk("hold_spacing_0", dtimes.size() > 1 ? dtimes[1] - dtimes[0] : -1, PER + 2);
    chk("hold_spacing_1", dtimes.size() > 2 ? dtimes[2] - dtimes[1] : -1, PER + 2);
    chk("hold_rd_data", int'(rd_data), 8'h3C);
    chk("hold_ctl_bad", bad_ctl, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
